// File: rtl/uart_image_loader.sv
// UART 8N1 receiver feeding a frame-buffer loader: waits for a sync byte, then
// streams PIXELS bytes into consecutive BRAM addresses, aborting on framing error or idle timeout.
`default_nettype none

module uart_image_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_BITS    = 16,
  parameter int         PIXELS       = 65536,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 10_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic                 timeout_err
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int CNT_W = ADDR_BITS + 1;

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PIXELS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_SYNC, L_DATA, L_DONE} ld_state_t;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        rx_state;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             byte_valid;
  logic             byte_err;

  ld_state_t        ld_state;
  logic [CNT_W-1:0] pix_cnt;
  logic [TO_W-1:0]  idle_cnt;

  // The synchroniser runs through reset so rx_prev sees the true line level
  // immediately; rx_prev resetting low means a line held low mid-byte cannot fake a start.
  always_ff @(posedge clk) begin
    rx_meta <= rx;
    rx_sync <= rx_meta;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_prev    <= 1'b0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (bit_cnt == BIT_LAST) begin
            byte_valid <= rx_sync;
            byte_err   <= !rx_sync;
            rx_state   <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state    <= L_SYNC;
      pix_cnt     <= '0;
      idle_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (ld_state)
        L_SYNC, L_DONE: begin
          if (byte_valid && shift == SYNC_BYTE) begin
            ld_state    <= L_DATA;
            pix_cnt     <= '0;
            idle_cnt    <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        L_DATA: begin
          // Completion is seen one cycle after the last write, so done follows the final wr_en.
          if (pix_cnt == CNT_FULL) begin
            ld_state <= L_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (byte_valid) begin
            wr_en    <= 1'b1;
            wr_addr  <= pix_cnt[ADDR_BITS-1:0];
            wr_data  <= shift;
            pix_cnt  <= pix_cnt + 1'b1;
            idle_cnt <= '0;
          end else if (byte_err) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            ld_state  <= L_SYNC;
          end else if (idle_cnt == TO_LIMIT) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            ld_state    <= L_SYNC;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: ld_state <= L_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: byte-level loader model with an expected-write
// queue, checked every cycle, plus directed literal checks per scenario.
`default_nettype none

module tb_uart_image_loader;

  localparam int CPB  = 16;
  localparam int AB   = 2;
  localparam int NPIX = 4;
  localparam int TO   = 400;
  localparam int LAT  = 156;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy, done, frame_err, timeout_err;

  uart_image_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_BITS(AB), .PIXELS(NPIX),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Loader model: 0 = waiting for sync, 1 = loading, 2 = frame complete
  int   m_state = 0;
  int   m_cnt = 0;
  bit   m_done = 0, m_ferr = 0, m_terr = 0;
  int   m_last = 0;
  bit   in_flight = 0;
  bit   started = 0;
  int   q_addr[$], q_data[$], q_due[$];
  int   wr_seen = 0;
  int   last_start = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0;
    m_done = 0; m_ferr = 0; m_terr = 0;
    in_flight = 0;
    q_addr.delete(); q_data.delete(); q_due.delete();
  endtask

  task automatic model_apply(input logic [7:0] d, input bit ok, input int s);
    if (!ok) begin
      if (m_state == 1) begin m_state = 0; m_ferr = 1; end
    end else if (m_state == 1) begin
      m_cnt++;
      m_last = s + LAT;
      if (m_cnt == NPIX) begin m_state = 2; m_done = 1; end
    end else if (d == 8'hA5) begin
      m_state = 1; m_cnt = 0;
      m_done = 0; m_ferr = 0; m_terr = 0;
      m_last = s + LAT;
    end
  endtask

  // One UART frame, 160 cycles; ok=0 drives a low stop bit then releases the line.
  task automatic send_byte(input logic [7:0] d, input bit ok);
    int s;
    rx = 1'b0;
    s = cyc;
    last_start = s;
    if (m_state == 1 && ok) begin
      q_addr.push_back(m_cnt); q_data.push_back(int'(d)); q_due.push_back(s + LAT);
    end
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = ok;
    tick(6);
    in_flight = 1;
    tick(8);
    model_apply(d, ok, s);
    in_flight = 0;
    tick(2);
    if (!ok) rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1);
    send_byte(b3, 1'b1); send_byte(b4, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_flags"}, int'({busy, done, frame_err, timeout_err}), 0);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (started && !reset) begin
      while (q_due.size() > 0 && cyc > q_due[0] + 1) begin
        tests++; fails++;
        $display("FAIL missed_write: got no write, expected addr %0d data 0x%0h by cycle %0d",
                 q_addr[0], q_data[0], q_due[0] + 1);
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
      end
      if (wr_en) begin
        wr_seen++;
        if (q_due.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          int dt;
          dt = cyc - q_due[0];
          check("wr_addr", int'(wr_addr), q_addr[0]);
          check("wr_data", int'(wr_data), q_data[0]);
          check("write_latency", (dt >= -1 && dt <= 1) ? LAT : LAT + dt, LAT);
          void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
        end
      end
      if (m_state == 1 && cyc == m_last + TO + 6) begin
        m_state = 0; m_terr = 1;
      end
      if (!in_flight && !(m_state == 1 && cyc >= m_last + TO - 4))
        check("flags_busy_done_ferr_terr", int'({busy, done, frame_err, timeout_err}),
              int'({m_state == 1, m_done, m_ferr, m_terr}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish, expected finish before 2 ms");
    $fatal(1, "time limit");
  end

  initial begin
    int base, waited, idle;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    model_reset();
    check_reset_values("reset");
    started = 1;
    tick(20);

    // 1: normal load, then a trailing byte after done
    base = wr_seen;
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44);
    tick(5);
    check("s1_writes", wr_seen - base, 4);
    check("s1_last_addr", int'(wr_addr), 3);
    check("s1_last_data", int'(wr_data), 8'h44);
    check("s1_done_busy", int'({done, busy}), 2'b10);
    send_byte(8'h55, 1'b1);
    tick(20);
    check("s1_no_write_after_done", wr_seen - base, 4);

    // 2: garbage, a short glitch, then a real frame (from done, A5 restarts)
    base = wr_seen;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h3C, 1'b1);
    check("s2_no_garbage_writes", wr_seen - base, 0);
    rx = 1'b0; tick(4); rx = 1'b1; tick(40);
    check("s2_glitch_no_write", wr_seen - base, 0);
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04);
    tick(5);
    check("s2_writes", wr_seen - base, 4);
    check("s2_last_data", int'(wr_data), 8'h04);
    tick(30);

    // 3: framing error mid-load, then A5 clears it; left idle long enough to time out
    base = wr_seen;
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b0);
    tick(20);
    check("s3_writes", wr_seen - base, 1);
    check("s3_frame_err", int'(frame_err), 1);
    check("s3_busy", int'(busy), 0);
    send_byte(8'hA5, 1'b1);
    tick(2);
    check("s3_ferr_cleared_busy", int'({frame_err, busy}), 2'b01);
    tick(500);

    // 4: timeout after one pixel, then a clean frame
    base = wr_seen;
    send_byte(8'hA5, 1'b1); send_byte(8'h77, 1'b1);
    waited = 0;
    while (!timeout_err && waited < 600) begin tick(1); waited++; end
    idle = cyc - 1 - (last_start + LAT);
    check("s4_timeout_idle_cycles", (idle >= 398 && idle <= 402) ? 400 : idle, 400);
    check("s4_busy_after_timeout", int'(busy), 0);
    check("s4_writes", wr_seen - base, 1);
    tick(100);
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04);
    tick(5);
    check("s4_done_after_reload", int'({done, timeout_err}), 2'b10);
    tick(30);

    // 5: sync value used as pixel data, then reload from done
    base = wr_seen;
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    tick(5);
    check("s5_writes", wr_seen - base, 4);
    check("s5_done", int'(done), 1);
    send_byte(8'hA5, 1'b1);
    tick(2);
    check("s5_reload_done_busy", int'({done, busy}), 2'b01);
    send_byte(8'h5A, 1'b1); send_byte(8'h6B, 1'b1);
    send_byte(8'h7C, 1'b1); send_byte(8'h8D, 1'b1);
    tick(5);
    check("s5_rewrites", wr_seen - base, 8);
    check("s5_rewrite_last_data", int'(wr_data), 8'h8D);
    tick(30);

    // 6: reset halfway through a pixel byte
    base = wr_seen;
    send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1);
    fork
      send_byte(8'h22, 1'b1);
      begin
        tick(80);
        reset = 1'b1;
        model_reset();
        tick(1);
        reset = 1'b0;
        check_reset_values("s6_reset");
      end
    join
    tick(300);
    check("s6_writes_before_reload", wr_seen - base, 1);
    send_frame(8'hA5, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    tick(5);
    check("s6_writes", wr_seen - base, 5);
    check("s6_done", int'(done), 1);
    tick(10);
    check("queue_drained", q_due.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_image_loader.md
# uart_image_loader

Receives a raw 8-bit-per-pixel image over the board's USB-UART and writes it into the sprite frame-buffer BRAM that the VGA display stage reads. It sits directly upstream of the VGA stage: it drives the BRAM write port (address, data, write enable) while the VGA stage keeps reading the other port. This lets a new 256×256 sprite be loaded at runtime without re-synthesising a `.txt` initialisation file. Pixel format is unchanged: R in [2:0], G in [5:3], B in [7:6].

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per UART bit (100 MHz / 115200 baud).
- `ADDR_BITS`, 16, frame-buffer address width.
- `PIXELS`, 65536, bytes per frame; must be ≤ 2^ADDR_BITS.
- `SYNC_BYTE`, 8'hA5, frame-start marker.
- `TIMEOUT_CLKS`, 10_000_000, maximum idle gap between data bytes (100 ms).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: UART line, asynchronous, idle high.
- `wr_en` out 1: one-cycle BRAM write strobe.
- `wr_addr` out ADDR_BITS: BRAM write address.
- `wr_data` out 8: pixel byte.
- `busy` out 1: frame load in progress.
- `done` out 1: full frame written; held.
- `frame_err` out 1: sticky; stop-bit error aborted a load.
- `timeout_err` out 1: sticky; inter-byte gap aborted a load.

## Operation
- `rx` passes through a 2-FF synchroniser. All logic uses the synchronised copy.
- **Receiver FSM**, 8N1, LSB first. States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a high→low transition moves to RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then sample. Low → RX_DATA. High → false start, return to RX_IDLE with no strobe.
  - RX_DATA: sample each bit CLKS_PER_BIT cycles after the previous sample, 8 samples in total.
  - RX_STOP: sample after CLKS_PER_BIT. High → byte-valid strobe. Low → framing-error strobe, byte discarded. Either way return to RX_IDLE at the mid-stop point.
- **Loader FSM**. States: L_SYNC, L_DATA, L_DONE.
  - L_SYNC: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: go to L_DATA, pixel count = 0, clear both error flags, clear `done`.
  - L_DATA: each valid byte → `wr_en`=1 for exactly one cycle, with `wr_addr`=count and `wr_data`=byte; then count++. SYNC_BYTE values in L_DATA are pixel data, not restarts.
  - L_DATA exit on completion: when the write with `wr_addr`=PIXELS-1 completes, go to L_DONE.
  - L_DATA exit on framing error: set `frame_err`, go to L_SYNC, no write for that byte.
  - L_DATA exit on timeout: the idle counter resets on every byte strobe (valid or error). When it reaches TIMEOUT_CLKS, set `timeout_err` and go to L_SYNC.
  - An aborted load leaves already-written addresses modified. There is no rollback.
  - L_DONE: `done` held at 1. SYNC_BYTE restarts exactly as from L_SYNC. Other bytes are ignored.
- `busy` = (state == L_DATA).
- Framing errors in L_SYNC or L_DONE set nothing.
- Counter widths:
  - bit-timing counter: ceil(log2(CLKS_PER_BIT)) bits.
  - pixel counter: ADDR_BITS+1 bits. No wrap is possible, because completion is detected before overflow.
  - timeout counter: saturates at TIMEOUT_CLKS.

## Timing
- Reset values:
  - receiver state RX_IDLE; loader state L_SYNC.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `done`=0, `frame_err`=0, `timeout_err`=0.
- Reset mid-byte or mid-frame aborts immediately. The next start bit is required before any new reception.
- All outputs are registered.
- `wr_addr`/`wr_data` are valid in the same cycle as `wr_en` and hold their values until the next write.
- `wr_en` asserts 2 cycles after the clock edge that samples the stop bit. This is 9.5·CLKS_PER_BIT + 4 ±1 cycles after the falling edge of the start bit at the `rx` pin.
- `busy` rises, and `done`/error flags clear, 2 cycles after the sync byte's stop-bit sample.
- `done` rises, and `busy` falls, in the cycle after the final `wr_en`.
- Back-to-back bytes (no idle between stop and next start) must be received without loss.
- Minimum `wr_en` spacing is 10·CLKS_PER_BIT cycles, so there are no write-port collisions.

## Test plan
Parameters for all scenarios: CLKS_PER_BIT=16, PIXELS=4, TIMEOUT_CLKS=400.

1. **Normal load.** Send A5,11,22,33,44 back-to-back.
   - Required: exactly 4 `wr_en` pulses with (addr,data) = (0,11),(1,22),(2,33),(3,44).
   - `busy` high between the sync byte and the final write; then `done`=1, `busy`=0.
   - A further byte 55 produces no write.
2. **Pre-sync garbage and false start.** Send 00,FF,3C, then a 4-cycle low glitch on `rx`, then A5,01,02,03,04.
   - Required: no writes before the sync byte; the glitch yields no byte; writes (0,01)…(3,04).
3. **Framing error.** Send A5,10, then a byte 20 with stop bit low.
   - Required: one write (0,10); `frame_err`=1; state L_SYNC; `busy`=0.
   - A following A5 clears `frame_err`.
4. **Timeout.** Send A5,77, then idle 500 cycles.
   - Required: one write (0,77); `timeout_err`=1 at idle cycle 400 (±2); `busy`=0.
   - Then A5,01,02,03,04 completes normally.
5. **Sync value as data, reload after done.** Send A5,A5,A5,A5,A5.
   - Required: writes (0,A5)…(3,A5); `done`=1.
   - Sending A5 again clears `done`, sets `busy`; then 4 bytes rewrite addresses 0–3.
6. **Reset mid-frame.** Send A5,11, then pulse `reset` for 1 cycle halfway through the next byte.
   - Required: all outputs at their reset values; the remainder of the interrupted byte produces no write; a following A5 plus 4 bytes writes from addr 0.
